// File: rtl/register_op_sequencer.sv
// -----------------------------------------------------------------------------
// register_op_sequencer
//   Command-driven control stage that sits directly upstream of a 32-bit
//   register (I / E / FunSel interface). One command is accepted per
//   valid/ready handshake and expanded into one register enable per clock:
//     DEC   : N decrement steps
//     INC   : N increment steps
//     LOAD  : a single load of the command data
//     LDDEC : a load followed by N decrement steps
//   Outputs are Moore-decoded from the state and the latched command.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_cmd_valid    command present on i_cmd_op / i_cmd_count / i_cmd_data
//   o_cmd_ready    command can be accepted (IDLE only)
//   i_cmd_op       00=DEC, 01=INC, 10=LOAD, 11=LDDEC
//   i_cmd_count    number of INC/DEC steps (ignored for LOAD)
//   i_cmd_data     load value for LOAD / LDDEC
//   i_abort        synchronous cancel of the active command
//   o_reg_i        register data input
//   o_reg_e        register enable
//   o_reg_funsel   register function: 000 dec, 001 inc, 010 load
//   o_busy         high while a command is in LOAD/STEP/DONE
//   o_done         one-cycle pulse on normal completion
//   o_steps_left   remaining INC/DEC steps
// -----------------------------------------------------------------------------
module register_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [CNT_W-1:0] i_cmd_count,
  input  logic [WIDTH-1:0] i_cmd_data,
  input  logic             i_abort,
  output logic [WIDTH-1:0] o_reg_i,
  output logic             o_reg_e,
  output logic [2:0]       o_reg_funsel,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_steps_left
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_DEC   = 2'b00;
  localparam logic [1:0] OP_INC   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_LDDEC = 2'b11;

  localparam logic [2:0] FS_DEC  = 3'b000;
  localparam logic [2:0] FS_INC  = 3'b001;
  localparam logic [2:0] FS_LOAD = 3'b010;

  logic [1:0]       r_state;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_steps;

  logic w_accept;
  logic w_steps_last;

  // Abort in IDLE takes priority over a simultaneous command.
  assign w_accept     = (r_state == S_IDLE) && i_cmd_valid && !i_abort;
  assign w_steps_last = (r_steps == CNT_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_DEC;
      r_count <= '0;
      r_data  <= '0;
      r_steps <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= i_cmd_op;
            r_count <= i_cmd_count;
            r_data  <= i_cmd_data;
            // A plain LOAD carries no steps, so its count field is not exposed.
            r_steps <= (i_cmd_op == OP_LOAD) ? '0 : i_cmd_count;
            if (i_cmd_op[1])
              r_state <= S_LOAD;
            else if (i_cmd_count == '0)
              r_state <= S_DONE;
            else
              r_state <= S_STEP;
          end
        end
        S_LOAD: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            r_steps <= '0;
          end else if ((r_op == OP_LOAD) || (r_count == '0)) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_STEP;
          end
        end
        S_STEP: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            r_steps <= '0;
          end else begin
            // Leaving on the last step keeps the counter from ever wrapping.
            r_steps <= r_steps - CNT_W'(1);
            if (w_steps_last)
              r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_steps <= '0;
        end
      endcase
    end
  end

  // Moore output decode
  assign o_cmd_ready  = (r_state == S_IDLE);
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);
  assign o_reg_e      = (r_state == S_LOAD) || (r_state == S_STEP);
  assign o_reg_i      = r_data;
  assign o_steps_left = r_steps;

  always_comb begin
    o_reg_funsel = FS_DEC;
    if (r_state == S_LOAD)
      o_reg_funsel = FS_LOAD;
    else if ((r_state == S_STEP) && (r_op == OP_INC))
      o_reg_funsel = FS_INC;
  end

endmodule

// File: tb/tb_register_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_register_op_sequencer
//   Drives register_op_sequencer into a behavioural 32-bit register and
//   compares each command against a reference that computes the expected
//   number of register actions, final register value and completion timing
//   directly from the command fields.
// -----------------------------------------------------------------------------
module tb_register_op_sequencer;

  localparam int WIDTH   = 32;
  localparam int CNT_W   = 8;
  localparam int CYC_MAX = 600;

  logic             clk;
  logic             rst_n;
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [1:0]       i_cmd_op;
  logic [CNT_W-1:0] i_cmd_count;
  logic [WIDTH-1:0] i_cmd_data;
  logic             i_abort;
  logic [WIDTH-1:0] o_reg_i;
  logic             o_reg_e;
  logic [2:0]       o_reg_funsel;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_steps_left;

  logic [WIDTH-1:0] q;

  int n_checks;
  int n_fail;

  register_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_op     (i_cmd_op),
    .i_cmd_count  (i_cmd_count),
    .i_cmd_data   (i_cmd_data),
    .i_abort      (i_abort),
    .o_reg_i      (o_reg_i),
    .o_reg_e      (o_reg_e),
    .o_reg_funsel (o_reg_funsel),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_steps_left (o_steps_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the downstream register (not reset by rst_n).
  initial q = '0;
  always @(posedge clk) begin
    if (o_reg_e) begin
      case (o_reg_funsel)
        3'b000:  q <= q - 32'd1;
        3'b001:  q <= q + 32'd1;
        3'b010:  q <= o_reg_i;
        default: q <= q;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and check everything it does until CmdReady returns.
  // abort_after < 0: no abort; otherwise abort is raised during the
  // (abort_after+1)-th enabled cycle, so that action still lands.
  task automatic run_cmd(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                         input logic [WIDTH-1:0] data, input int abort_after);
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] q_exp;
    int total, n_exp, k, n_e, n_done, done_at, ready_at, wait_c;
    logic is_load;
    logic [2:0] fs_exp;

    wait_c = 0;
    while (!o_cmd_ready && wait_c < 20) begin
      tick();
      wait_c++;
    end
    chk("ready_before_cmd", 64'(o_cmd_ready), 64'(1));

    total = (op == 2'b10) ? 1 : ((op == 2'b11) ? 1 + int'(cnt) : int'(cnt));

    q0 = q;
    i_cmd_op    = op;
    i_cmd_count = cnt;
    i_cmd_data  = data;
    i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;

    n_e = 0; n_done = 0; done_at = -1; ready_at = -1;
    for (int c = 1; c <= CYC_MAX; c++) begin
      if (o_cmd_ready) begin
        ready_at = c;
        break;
      end
      chk("busy", 64'(o_busy), 64'(1));
      is_load = 1'b0;
      if (o_reg_e) begin
        n_e++;
        is_load = op[1] && (n_e == 1);
        fs_exp  = is_load ? 3'b010 : ((op == 2'b01) ? 3'b001 : 3'b000);
        chk("funsel", 64'(o_reg_funsel), 64'(fs_exp));
        chk("reg_i", 64'(o_reg_i), 64'(data));
        if (!is_load)
          chk("steps_left", 64'(o_steps_left),
              64'(int'(cnt) - (n_e - (op[1] ? 2 : 1))));
        if (abort_after >= 0 && n_e == abort_after + 1)
          i_abort = 1'b1;
      end else begin
        chk("funsel_idle", 64'(o_reg_funsel), 64'(0));
      end
      if (o_done) begin
        n_done++;
        done_at = c;
      end
      tick();
      i_abort = 1'b0;
      if (is_load)
        chk("q_after_load", 64'(q), 64'(data));
    end

    if (ready_at < 0) begin
      chk("timeout_ready", 64'(0), 64'(1));
    end

    if (abort_after >= 0) begin
      n_exp = abort_after + 1;
      chk("abort_done_cnt", 64'(n_done), 64'(0));
      chk("abort_ready_at", 64'(ready_at), 64'(abort_after + 2));
    end else begin
      n_exp = total;
      chk("done_cnt", 64'(n_done), 64'(1));
      chk("done_at", 64'(done_at), 64'(total + 1));
      chk("ready_at", 64'(ready_at), 64'(total + 2));
    end
    chk("enable_cycles", 64'(n_e), 64'(n_exp));

    q_exp = q0;
    k = n_exp;
    if (op[1]) begin
      q_exp = data;
      k--;
    end
    if (op != 2'b10)
      q_exp = (op == 2'b01) ? q_exp + WIDTH'(k) : q_exp - WIDTH'(k);
    chk("q_final", 64'(q), 64'(q_exp));
    chk("steps_left_idle", 64'(o_steps_left), 64'(0));
    chk("reg_e_idle", 64'(o_reg_e), 64'(0));
  endtask

  initial begin
    int ab, tot;
    logic [1:0] rop;
    logic [CNT_W-1:0] rcnt;

    n_checks = 0;
    n_fail   = 0;
    rst_n       = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_op    = 2'b00;
    i_cmd_count = '0;
    i_cmd_data  = '0;
    i_abort     = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_ready", 64'(o_cmd_ready), 64'(1));
    chk("rst_reg_e", 64'(o_reg_e), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("rel_ready", 64'(o_cmd_ready), 64'(1));
    chk("rel_reg_e", 64'(o_reg_e), 64'(0));
    chk("rel_funsel", 64'(o_reg_funsel), 64'(0));
    chk("rel_reg_i", 64'(o_reg_i), 64'(0));
    chk("rel_done", 64'(o_done), 64'(0));
    chk("rel_busy", 64'(o_busy), 64'(0));
    chk("rel_steps", 64'(o_steps_left), 64'(0));

    // INC 3 from 0x1234
    run_cmd(2'b10, 8'd0, 32'h0000_1234, -1);
    run_cmd(2'b01, 8'd3, 32'h0000_1234, -1);
    chk("inc3_q", 64'(q), 64'h1237);

    // LDDEC 0x100, 2
    run_cmd(2'b11, 8'd2, 32'h0000_0100, -1);
    chk("lddec_q", 64'(q), 64'hFE);

    // DEC 0 leaves Q untouched
    run_cmd(2'b10, 8'd0, 32'h0000_5678, -1);
    run_cmd(2'b00, 8'd0, 32'h0000_5678, -1);
    chk("dec0_q", 64'(q), 64'h5678);

    // INC 5 aborted after the first step -> two enabled edges
    run_cmd(2'b10, 8'd0, 32'h0000_0010, -1);
    run_cmd(2'b01, 8'd5, 32'h0000_0010, 1);
    chk("abort_q", 64'(q), 64'h12);

    // Abort in IDLE beats CmdValid
    i_cmd_op = 2'b01; i_cmd_count = 8'd4; i_cmd_valid = 1'b1; i_abort = 1'b1;
    tick();
    i_cmd_valid = 1'b0; i_abort = 1'b0;
    chk("idle_abort_ready", 64'(o_cmd_ready), 64'(1));
    chk("idle_abort_busy", 64'(o_busy), 64'(0));

    // Maximum step count
    run_cmd(2'b01, 8'd255, 32'h0, -1);

    // Reset during LOAD, before the load edge
    run_cmd(2'b10, 8'd0, 32'h0000_5678, -1);
    i_cmd_op = 2'b10; i_cmd_data = 32'hDEAD_BEEF; i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    chk("load_reg_e", 64'(o_reg_e), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reg_e", 64'(o_reg_e), 64'(0));
    chk("async_funsel", 64'(o_reg_funsel), 64'(0));
    chk("async_ready", 64'(o_cmd_ready), 64'(1));
    chk("async_done", 64'(o_done), 64'(0));
    tick();
    chk("rst_load_q", 64'(q), 64'h5678);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 64'(o_cmd_ready), 64'(1));
    chk("post_rst_reg_i", 64'(o_reg_i), 64'(0));

    // Randomized commands
    for (int n = 0; n < 40; n++) begin
      rop  = 2'($urandom_range(0, 3));
      rcnt = CNT_W'($urandom_range(0, 12));
      tot  = (rop == 2'b10) ? 1 : ((rop == 2'b11) ? 1 + int'(rcnt) : int'(rcnt));
      ab   = -1;
      if (tot > 0 && $urandom_range(0, 3) == 0)
        ab = int'($urandom_range(0, tot - 1));
      run_cmd(rop, rcnt, $urandom, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
